// File: rtl/coso_match_ctrl_mc_pkg.sv
// Shared types and helpers for the multi-channel COSO matching controller.
// Holds the channel state encoding, default window/config sizes and the threshold test.
package coso_match_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        FAIL   = 2'd2
    } chan_state_e;

    localparam int NB_SAMPLES_LOG_DFLT = 7;
    localparam int RO_LENGTH_DFLT      = 3;
    localparam int WINDOW_SIZE         = 1 << NB_SAMPLES_LOG_DFLT;
    localparam int CFG_WIDTH           = 4 * RO_LENGTH_DFLT;

    // Inclusive low, exclusive high; an empty or inverted range accepts nothing.
    function automatic logic in_range(input logic [31:0] val,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (lo < hi) && (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/coso_match_ctrl_mc_if.sv
// Coherent-sampler request/count/acknowledge bundle for all channels.
// The sampler side drives requests and counts; the controller returns acknowledges.
interface coso_match_ctrl_mc_if #(
    parameter int NCH         = 2,
    parameter int CSCntLength = 16
);
    logic [NCH-1:0]             CSReq;
    logic [NCH*CSCntLength-1:0] CSCnt;
    logic [NCH-1:0]             CSAck;

    modport master (output CSReq, output CSCnt, input CSAck);
    modport slave  (input CSReq, input CSCnt, output CSAck);
endinterface

// File: rtl/coso_match_ctrl_mc_chan.sv
// One channel of the matching controller: windowed good-sample counting,
// configuration scan while searching, and miss tracking once locked.
module coso_match_chan
    import coso_match_pkg::*;
#(
    parameter int CSCntLength  = 16,
    parameter int NBCheckbits  = 10,
    parameter int ROLength     = 3,
    parameter int NBSamplesLog = 7,
    parameter int SAMPLES_MIN  = 64,
    parameter int SAMPLES_LOST = 32,
    parameter int MAX_MISSES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBCheckbits-1:0]   thresh_l_i,
    input  logic [NBCheckbits-1:0]   thresh_h_i,
    input  logic [4*ROLength-1:0]    cfg_seed_i,
    input  logic                     restart_i,
    input  logic                     cs_req_i,
    input  logic [CSCntLength-1:0]   cs_cnt_i,
    output logic                     cs_ack_o,
    output logic [4*ROLength-1:0]    ro_sel_o,
    output logic                     matched_o,
    output logic                     no_found_o
);
    localparam int CW  = 4 * ROLength;
    localparam int SCW = NBSamplesLog + 1;
    localparam int TW  = CW + 1;
    localparam int MW  = $clog2(MAX_MISSES + 1);

    localparam logic [SCW-1:0] WIN_END    = SCW'(1 << NBSamplesLog);
    localparam logic [SCW-1:0] MIN_GOOD   = SCW'(SAMPLES_MIN);
    localparam logic [SCW-1:0] LOST_GOOD  = SCW'(SAMPLES_LOST);
    localparam logic [TW-1:0]  ALL_TRIED  = TW'(1 << CW);
    localparam logic [MW-1:0]  MISS_LIMIT = MW'(MAX_MISSES);

    chan_state_e     state_q, state_d;
    logic [CW-1:0]   ro_sel_q, ro_sel_d;
    logic [SCW-1:0]  sample_cnt_q, sample_cnt_d;
    logic [SCW-1:0]  good_cnt_q, good_cnt_d;
    logic [TW-1:0]   tried_q, tried_d;
    logic [MW-1:0]   misses_q, misses_d;
    logic            ack_q, ack_d;
    logic            matched_q, matched_d;
    logic            no_found_q, no_found_d;

    logic            accept;
    logic            sample_good;
    logic [SCW-1:0]  sample_nxt;
    logic [SCW-1:0]  good_nxt;

    // A request seen while its acknowledge is still up belongs to the previous sample.
    assign accept      = cs_req_i & ~ack_q;
    assign sample_good = in_range(32'(cs_cnt_i[CSCntLength-1 -: NBCheckbits]),
                                  32'(thresh_l_i), 32'(thresh_h_i));
    assign sample_nxt  = sample_cnt_q + SCW'(1);
    assign good_nxt    = good_cnt_q + SCW'(sample_good);

    always_comb begin
        state_d      = state_q;
        ro_sel_d     = ro_sel_q;
        sample_cnt_d = sample_cnt_q;
        good_cnt_d   = good_cnt_q;
        tried_d      = tried_q;
        misses_d     = misses_q;
        ack_d        = 1'b0;
        matched_d    = matched_q;
        no_found_d   = no_found_q;

        if (restart_i) begin
            state_d      = SEARCH;
            ro_sel_d     = cfg_seed_i;
            sample_cnt_d = '0;
            good_cnt_d   = '0;
            tried_d      = '0;
            misses_d     = '0;
            matched_d    = 1'b0;
            no_found_d   = 1'b0;
        end else if (accept) begin
            ack_d = 1'b1;
            if (state_q != FAIL) begin
                sample_cnt_d = sample_nxt;
                good_cnt_d   = good_nxt;
                if (sample_nxt == WIN_END) begin
                    sample_cnt_d = '0;
                    good_cnt_d   = '0;
                    case (state_q)
                        SEARCH: begin
                            if (good_nxt >= MIN_GOOD) begin
                                state_d   = LOCKED;
                                matched_d = 1'b1;
                                misses_d  = '0;
                            end else begin
                                tried_d = tried_q + TW'(1);
                                // Last configuration exhausted: freeze selection on it.
                                if (tried_d == ALL_TRIED) begin
                                    state_d    = FAIL;
                                    no_found_d = 1'b1;
                                end else begin
                                    ro_sel_d = ro_sel_q + CW'(1);
                                end
                            end
                        end
                        LOCKED: begin
                            if (good_nxt >= MIN_GOOD) begin
                                misses_d = '0;
                            end else if (good_nxt < LOST_GOOD) begin
                                misses_d = misses_q + MW'(1);
                            end
                            if (misses_d == MISS_LIMIT) begin
                                state_d   = SEARCH;
                                matched_d = 1'b0;
                                ro_sel_d  = ro_sel_q + CW'(1);
                                tried_d   = TW'(1);
                                misses_d  = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            ro_sel_q     <= '0;
            sample_cnt_q <= '0;
            good_cnt_q   <= '0;
            tried_q      <= '0;
            misses_q     <= '0;
            ack_q        <= 1'b0;
            matched_q    <= 1'b0;
            no_found_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ro_sel_q     <= ro_sel_d;
            sample_cnt_q <= sample_cnt_d;
            good_cnt_q   <= good_cnt_d;
            tried_q      <= tried_d;
            misses_q     <= misses_d;
            ack_q        <= ack_d;
            matched_q    <= matched_d;
            no_found_q   <= no_found_d;
        end
    end

    assign cs_ack_o   = ack_q;
    assign ro_sel_o   = ro_sel_q;
    assign matched_o  = matched_q;
    assign no_found_o = no_found_q;

endmodule

// File: rtl/coso_match_ctrl_mc.sv
// Multi-channel COSO matching controller: one independent channel FSM per
// coherent sampler plus registered aggregate lock/failure flags.
module coso_match_ctrl_mc
    import coso_match_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int CSCntLength  = 16,
    parameter int NBCheckbits  = 10,
    parameter int ROLength     = RO_LENGTH_DFLT,
    parameter int NBSamplesLog = NB_SAMPLES_LOG_DFLT,
    parameter int SAMPLES_MIN  = 64,
    parameter int SAMPLES_LOST = 32,
    parameter int MAX_MISSES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBCheckbits-1:0]    threshL,
    input  logic [NBCheckbits-1:0]    threshH,
    input  logic [4*ROLength-1:0]     cfgSeed,
    input  logic                      restart,
    coso_match_ctrl_mc_if.slave       cs,
    output logic [NCH*2*ROLength-1:0] RO0Sel,
    output logic [NCH*2*ROLength-1:0] RO1Sel,
    output logic [NCH-1:0]            matched,
    output logic [NCH-1:0]            noFound,
    output logic                      allMatched,
    output logic                      anyNoFound
);
    logic [NCH-1:0] cs_ack;
    logic           all_matched_q;
    logic           any_no_found_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [4*ROLength-1:0] ro_sel;

            coso_match_chan #(
                .CSCntLength  (CSCntLength),
                .NBCheckbits  (NBCheckbits),
                .ROLength     (ROLength),
                .NBSamplesLog (NBSamplesLog),
                .SAMPLES_MIN  (SAMPLES_MIN),
                .SAMPLES_LOST (SAMPLES_LOST),
                .MAX_MISSES   (MAX_MISSES)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .thresh_l_i (threshL),
                .thresh_h_i (threshH),
                .cfg_seed_i (cfgSeed),
                .restart_i  (restart),
                .cs_req_i   (cs.CSReq[gi]),
                .cs_cnt_i   (cs.CSCnt[gi*CSCntLength +: CSCntLength]),
                .cs_ack_o   (cs_ack[gi]),
                .ro_sel_o   (ro_sel),
                .matched_o  (matched[gi]),
                .no_found_o (noFound[gi])
            );

            assign RO0Sel[gi*2*ROLength +: 2*ROLength] = ro_sel[2*ROLength-1:0];
            assign RO1Sel[gi*2*ROLength +: 2*ROLength] = ro_sel[4*ROLength-1:2*ROLength];
        end
    endgenerate

    assign cs.CSAck = cs_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_matched_q  <= 1'b0;
            any_no_found_q <= 1'b0;
        end else begin
            all_matched_q  <= &matched;
            any_no_found_q <= |noFound;
        end
    end

    assign allMatched = all_matched_q;
    assign anyNoFound = any_no_found_q;

endmodule

// File: tb/tb_coso_match_ctrl_mc.sv
// Randomized self-checking bench for coso_match_ctrl_mc against a window-level
// reference model (per-channel queues of good/bad flags evaluated at window end).
module tb_coso_match_ctrl_mc;

    localparam int NCH   = 2;
    localparam int CSW   = 16;
    localparam int NBC   = 10;
    localparam int ROL   = 1;
    localparam int NBL   = 3;
    localparam int SMIN  = 6;
    localparam int SLOST = 3;
    localparam int MAXM  = 2;
    localparam int W     = 1 << NBL;
    localparam int CFGW  = 4 * ROL;
    localparam int NCFG  = 1 << CFGW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NBC-1:0]        threshL, threshH;
    logic [CFGW-1:0]       cfgSeed;
    logic                  restart;
    logic [NCH*2*ROL-1:0]  RO0Sel, RO1Sel;
    logic [NCH-1:0]        matched, noFound;
    logic                  allMatched, anyNoFound;

    coso_match_ctrl_mc_if #(.NCH(NCH), .CSCntLength(CSW)) cs_if ();

    always #5 clk = ~clk;

    coso_match_ctrl_mc #(
        .NCH(NCH), .CSCntLength(CSW), .NBCheckbits(NBC), .ROLength(ROL),
        .NBSamplesLog(NBL), .SAMPLES_MIN(SMIN), .SAMPLES_LOST(SLOST), .MAX_MISSES(MAXM)
    ) dut (
        .clk(clk), .rst(rst), .threshL(threshL), .threshH(threshH),
        .cfgSeed(cfgSeed), .restart(restart), .cs(cs_if.slave),
        .RO0Sel(RO0Sel), .RO1Sel(RO1Sel), .matched(matched), .noFound(noFound),
        .allMatched(allMatched), .anyNoFound(anyNoFound)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_rosel  [NCH];
    bit m_locked [NCH];
    bit m_fail   [NCH];
    bit m_ack    [NCH];
    int m_tried  [NCH];
    int m_misses [NCH];
    int m_win    [NCH][$];
    bit m_all, m_any;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_restart(input int seed);
        for (int i = 0; i < NCH; i++) begin
            m_rosel[i] = seed; m_locked[i] = 0; m_fail[i] = 0; m_ack[i] = 0;
            m_tried[i] = 0; m_misses[i] = 0; m_win[i].delete();
        end
    endtask

    task automatic model_reset();
        model_restart(0);
        m_all = 0; m_any = 0;
    endtask

    task automatic window_end(input int i);
        int g;
        g = 0;
        foreach (m_win[i][k]) g += m_win[i][k];
        m_win[i].delete();
        if (!m_locked[i]) begin
            if (g >= SMIN) begin
                m_locked[i] = 1; m_misses[i] = 0;
            end else begin
                m_tried[i]++;
                if (m_tried[i] == NCFG) m_fail[i] = 1;
                else m_rosel[i] = (m_rosel[i] + 1) % NCFG;
            end
        end else begin
            if (g >= SMIN) m_misses[i] = 0;
            else if (g < SLOST) m_misses[i]++;
            if (m_misses[i] == MAXM) begin
                m_locked[i] = 0; m_rosel[i] = (m_rosel[i] + 1) % NCFG;
                m_tried[i] = 1; m_misses[i] = 0;
            end
        end
        $display("ch%0d window good=%0d locked=%0d fail=%0d rosel=%0h misses=%0d",
                 i, g, m_locked[i], m_fail[i], m_rosel[i], m_misses[i]);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit nall, nany, acc;
        int v;
        nall = 1; nany = 0;
        for (int i = 0; i < NCH; i++) begin
            nall &= m_locked[i];
            nany |= m_fail[i];
        end
        if (restart) begin
            model_restart(int'(cfgSeed));
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc = cs_if.CSReq[i] && !m_ack[i];
                m_ack[i] = acc;
                if (acc && !m_fail[i]) begin
                    v = int'(cs_if.CSCnt[i*CSW +: CSW]) >> (CSW - NBC);
                    m_win[i].push_back((threshL < threshH && v >= int'(threshL) && v < int'(threshH)) ? 1 : 0);
                    if (m_win[i].size() == W) window_end(i);
                end
            end
        end
        m_all = nall; m_any = nany;
    endtask

    task automatic compare_all();
        logic [NCH-1:0]       e_ack, e_m, e_nf;
        logic [NCH*2*ROL-1:0] e_ro0, e_ro1;
        logic [CFGW-1:0]      r;
        for (int i = 0; i < NCH; i++) begin
            e_ack[i] = m_ack[i];
            e_m[i]   = m_locked[i];
            e_nf[i]  = m_fail[i];
            r = CFGW'(m_rosel[i]);
            e_ro0[i*2*ROL +: 2*ROL] = r[2*ROL-1:0];
            e_ro1[i*2*ROL +: 2*ROL] = r[CFGW-1:2*ROL];
        end
        check_val("ack", 64'(cs_if.CSAck), 64'(e_ack));
        check_val("matched", 64'(matched), 64'(e_m));
        check_val("noFound", 64'(noFound), 64'(e_nf));
        check_val("RO0Sel", 64'(RO0Sel), 64'(e_ro0));
        check_val("RO1Sel", 64'(RO1Sel), 64'(e_ro1));
        check_val("allMatched", 64'(allMatched), 64'(m_all));
        check_val("anyNoFound", 64'(anyNoFound), 64'(m_any));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [CSW-1:0] gen_cnt(input bit good);
        logic [NBC-1:0] msb;
        if (good) msb = NBC'($urandom_range(10'h1FF, 10'h100));
        else if ($urandom_range(1, 0) == 1) msb = NBC'($urandom_range(10'h0FF, 0));
        else msb = NBC'($urandom_range(10'h3FF, 10'h200));
        return {msb, 6'($urandom)};
    endfunction

    task automatic set_ch(input int i, input bit req, input bit good);
        cs_if.CSReq[i] = req;
        cs_if.CSCnt[i*CSW +: CSW] = gen_cnt(good);
    endtask

    task automatic feed_sample(input int i, input bit good);
        set_ch(i, 1, good);
        step();
        set_ch(i, 0, 0);
        step();
    endtask

    task automatic feed_window(input int i, input int ngood);
        for (int k = 0; k < W; k++) feed_sample(i, k < ngood);
    endtask

    task automatic pulse_restart(input logic [CFGW-1:0] seed);
        cfgSeed = seed; restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        int acks, gp[NCH], rp[NCH];
        rst = 1'b1; restart = 1'b0; cfgSeed = '0;
        threshL = 10'h100; threshH = 10'h200;
        cs_if.CSReq = '0; cs_if.CSCnt = '0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Channel 0 locks on 8 in-range samples; channel 1 idles.
        for (int k = 0; k < W; k++) begin
            set_ch(0, 1, 1);
            step();
            check_val("t1_matched", 64'(matched[0]), (k == W - 1) ? 64'd1 : 64'd0);
            set_ch(0, 0, 0);
            step();
        end
        check_val("t1_ro0", 64'(RO0Sel[1:0]), 64'd0);
        step();
        check_val("t1_all", 64'(allMatched), 64'd0);

        // Exhaust every configuration on channel 0.
        pulse_restart(4'h0);
        for (int c = 0; c < 600 && !m_fail[0]; c++) begin
            set_ch(0, 1, 0);
            step();
        end
        check_val("t2_noFound", 64'(noFound[0]), 64'd1);
        check_val("t2_rosel", 64'({RO1Sel[1:0], RO0Sel[1:0]}), 64'hF);
        set_ch(0, 0, 0);
        step();
        check_val("t2_anyNoFound", 64'(anyNoFound), 64'd1);

        // Request held three cycles yields two acceptances.
        step();
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            set_ch(1, 1, 1);
            step();
            acks += int'(cs_if.CSAck[1]);
        end
        set_ch(1, 0, 0);
        step();
        acks += int'(cs_if.CSAck[1]);
        check_val("t4_acks", 64'(acks), 64'd2);
        step();

        // Restart coinciding with an acceptance drops that sample.
        feed_window(1, 8);
        set_ch(0, 1, 1); set_ch(1, 1, 1);
        pulse_restart(4'h9);
        check_val("t5_ack", 64'(cs_if.CSAck), 64'd0);
        check_val("t5_matched", 64'(matched), 64'd0);
        check_val("t5_noFound", 64'(noFound), 64'd0);
        check_val("t5_rosel0", 64'({RO1Sel[1:0], RO0Sel[1:0]}), 64'h9);
        set_ch(0, 0, 0); set_ch(1, 0, 0);
        step();

        // Lock loss: miss, hold, miss.
        pulse_restart(4'h0);
        feed_window(0, 8);
        check_val("t3_lock", 64'(matched[0]), 64'd1);
        feed_window(0, 1);
        check_val("t3_miss1", 64'(matched[0]), 64'd1);
        feed_window(0, 4);
        check_val("t3_hold", 64'(matched[0]), 64'd1);
        feed_window(0, 1);
        check_val("t3_drop", 64'(matched[0]), 64'd0);
        check_val("t3_rosel", 64'({RO1Sel[1:0], RO0Sel[1:0]}), 64'h1);

        // Randomized traffic on both channels.
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) begin
                for (int i = 0; i < NCH; i++) begin
                    gp[i] = $urandom_range(100, 0);
                    rp[i] = $urandom_range(100, 20);
                end
                if ($urandom_range(9, 0) == 0) begin
                    threshL = 10'h200; threshH = 10'h100;
                end else if ($urandom_range(9, 0) == 0) begin
                    threshL = NBC'($urandom); threshH = NBC'($urandom);
                end else begin
                    threshL = 10'h100; threshH = 10'h200;
                end
            end
            for (int i = 0; i < NCH; i++)
                set_ch(i, $urandom_range(99, 0) < rp[i], $urandom_range(99, 0) < gp[i]);
            if ($urandom_range(299, 0) == 0) begin
                cfgSeed = CFGW'($urandom); restart = 1'b1;
            end
            step();
            restart = 1'b0;
        end
        threshL = 10'h100; threshH = 10'h200;
        cs_if.CSReq = '0;
        step();
        step();

        // Asynchronous reset mid-window, then a full fresh window.
        pulse_restart(4'h5);
        for (int k = 0; k < 3; k++) feed_sample(0, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        rst = 1'b0;
        for (int k = 0; k < W; k++) begin
            feed_sample(0, 1);
            check_val("t6_matched", 64'(matched[0]), (k == W - 1) ? 64'd1 : 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
